// File: rtl/t03_game_pkg.sv
// Shared types and constants for the team 03 pushbutton fighting game.
package t03_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    P1_WIN,
    P2_WIN,
    DRAW
  } game_state_t;

  localparam int unsigned PB_P1_LEFT  = 0;
  localparam int unsigned PB_P1_RIGHT = 1;
  localparam int unsigned PB_P1_ATK   = 2;
  localparam int unsigned PB_P2_LEFT  = 4;
  localparam int unsigned PB_P2_RIGHT = 5;
  localparam int unsigned PB_P2_ATK   = 6;
  localparam int unsigned PB_START    = 7;

  // Segment patterns for digits 0..9, bit0=a .. bit6=g, dp off.
  localparam logic [7:0] SEG_LUT [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

endpackage

// File: rtl/t03_ssdec.sv
// Combinational 4-bit digit to seven-segment decoder; non-decimal codes blank.
module t03_ssdec
  import t03_game_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  always_comb begin
    seg = '0;
    if (digit <= 4'd9) seg = SEG_LUT[digit];
  end

endmodule

// File: rtl/t03_top.sv
// Team 03 two-player fighting game top: pb sync/edge detect, game FSM,
// positions, health and cooldowns, with registered board outputs.
module t03_top
  import t03_game_pkg::*;
#(
  parameter int unsigned HEALTH_INIT = 9,
  parameter int unsigned COOLDOWN    = 50,
  parameter int unsigned P1_START    = 3,
  parameter int unsigned P2_START    = 12
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  input  logic [7:0]  rxdata,
  input  logic        txready,
  input  logic        rxready,
  output logic [7:0]  left,
  output logic [7:0]  right,
  output logic [7:0]  ss7,
  output logic [7:0]  ss6,
  output logic [7:0]  ss5,
  output logic [7:0]  ss4,
  output logic [7:0]  ss3,
  output logic [7:0]  ss2,
  output logic [7:0]  ss1,
  output logic [7:0]  ss0,
  output logic        red,
  output logic        green,
  output logic        blue,
  output logic [7:0]  txdata,
  output logic        txclk,
  output logic        rxclk
);

  localparam logic [15:0] STRIP_INIT = (16'd1 << P1_START) | (16'd1 << P2_START);
  localparam logic [7:0]  SEG_INIT   = SEG_LUT[4'(HEALTH_INIT)];

  game_state_t state;
  logic [7:0]  s1, s2, prev, rise;
  logic [3:0]  x1, x2, h1, h2, x1_n, x2_n;
  logic [15:0] cd1, cd2, strip;
  logic [7:0]  seg_h1, seg_h2;
  logic        adj;
  logic        unused_inputs;

  assign rise  = s2 & ~prev;
  assign adj   = (x2 - x1) == 4'd1;
  assign strip = (16'd1 << x1) | (16'd1 << x2);

  // P2's left move is checked against P1's new position, so simultaneous
  // P1-right / P2-left at gap 2 lets P1 move and blocks P2.
  always_comb begin
    x1_n = x1;
    if (rise[PB_P1_LEFT] && x1 != 4'd0)
      x1_n = x1 - 4'd1;
    else if (rise[PB_P1_RIGHT] && (x1 + 4'd1) < x2)
      x1_n = x1 + 4'd1;
    x2_n = x2;
    if (rise[PB_P2_RIGHT] && x2 != 4'd15)
      x2_n = x2 + 4'd1;
    else if (rise[PB_P2_LEFT] && (x2 - 4'd1) > x1_n)
      x2_n = x2 - 4'd1;
  end

  t03_ssdec u_ss_h1 (.digit(h1), .seg(seg_h1));
  t03_ssdec u_ss_h2 (.digit(h2), .seg(seg_h2));

  always_ff @(posedge hz100) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      state <= IDLE;
      x1    <= 4'(P1_START);
      x2    <= 4'(P2_START);
      h1    <= 4'(HEALTH_INIT);
      h2    <= 4'(HEALTH_INIT);
      cd1   <= '0;
      cd2   <= '0;
      {left, right} <= STRIP_INIT;
      ss7   <= SEG_INIT;
      ss0   <= SEG_INIT;
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      s1   <= pb[7:0];
      s2   <= s1;
      prev <= s2;
      if (cd1 != '0) cd1 <= cd1 - 16'd1;
      if (cd2 != '0) cd2 <= cd2 - 16'd1;

      {left, right} <= strip;
      ss7   <= seg_h1;
      ss0   <= seg_h2;
      red   <= (state == P1_WIN) || (state == DRAW);
      green <= (state == PLAY);
      blue  <= (state == P2_WIN) || (state == DRAW);

      case (state)
        IDLE: if (rise[PB_START]) state <= PLAY;
        PLAY: begin
          if (h2 == 4'd0 && h1 != 4'd0)      state <= P1_WIN;
          else if (h1 == 4'd0 && h2 != 4'd0) state <= P2_WIN;
          else if (h1 == 4'd0 && h2 == 4'd0) state <= DRAW;
          else begin
            x1 <= x1_n;
            x2 <= x2_n;
            if (rise[PB_P1_ATK] && cd1 == '0) begin
              cd1 <= 16'(COOLDOWN);
              if (adj && h2 != 4'd0) h2 <= h2 - 4'd1;
            end
            if (rise[PB_P2_ATK] && cd2 == '0) begin
              cd2 <= 16'(COOLDOWN);
              if (adj && h1 != 4'd0) h1 <= h1 - 4'd1;
            end
          end
        end
        P1_WIN, P2_WIN, DRAW: begin
          if (rise[PB_START]) begin
            state <= IDLE;
            x1    <= 4'(P1_START);
            x2    <= 4'(P2_START);
            h1    <= 4'(HEALTH_INIT);
            h2    <= 4'(HEALTH_INIT);
            cd1   <= '0;
            cd2   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ss6    = '0;
  assign ss5    = '0;
  assign ss4    = '0;
  assign ss3    = '0;
  assign ss2    = '0;
  assign ss1    = '0;
  assign txdata = '0;
  assign txclk  = 1'b0;
  assign rxclk  = 1'b0;

  assign unused_inputs = ^{pb[20:8], pb[3], rxdata, txready, rxready, rise[3]};

endmodule

// File: tb/tb_t03_top.sv
// Directed bench for t03_top: movement limits, attacks with cooldown, win, draw, restart.
module tb_t03_top;

  logic        hz100 = 1'b0;
  logic        reset;
  logic [20:0] pb;
  logic [7:0]  rxdata;
  logic        txready, rxready;
  logic [7:0]  left, right, ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0;
  logic        red, green, blue;
  logic [7:0]  txdata;
  logic        txclk, rxclk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [7:0] SEGT [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  localparam logic [20:0] P1L = 21'h1, P1R = 21'h2, P1A = 21'h4;
  localparam logic [20:0] P2L = 21'h10, P2R = 21'h20, P2A = 21'h40, ST = 21'h80;

  t03_top #(.HEALTH_INIT(9), .COOLDOWN(50), .P1_START(3), .P2_START(12)) dut (
    .hz100(hz100), .reset(reset), .pb(pb), .rxdata(rxdata),
    .txready(txready), .rxready(rxready),
    .left(left), .right(right),
    .ss7(ss7), .ss6(ss6), .ss5(ss5), .ss4(ss4),
    .ss3(ss3), .ss2(ss2), .ss1(ss1), .ss0(ss0),
    .red(red), .green(green), .blue(blue),
    .txdata(txdata), .txclk(txclk), .rxclk(rxclk)
  );

  always #5 hz100 = ~hz100;

  task automatic tick(input int n);
    repeat (n) @(posedge hz100);
    #1;
  endtask

  task automatic pulse(input logic [20:0] m);
    pb = pb | m;
    tick(2);
    pb = pb & ~m;
    tick(3);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pb = '0; rxdata = 8'h5A; txready = 1'b1; rxready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);

    check("rst_left",  {8'h00, left},  16'h0010);
    check("rst_right", {8'h00, right}, 16'h0008);
    check("rst_ss7",   {8'h00, ss7},   16'h006F);
    check("rst_ss0",   {8'h00, ss0},   16'h006F);
    check("rst_ss3",   {8'h00, ss3},   16'h0000);
    check("rst_rgb",   {13'h0, red, green, blue}, 16'h0000);
    check("rst_tx",    {6'h0, txclk, rxclk, txdata}, 16'h0000);

    pulse(P1L);
    check("idle_move_ignored", {left, right}, 16'h1008);
    pulse(ST);
    check("start_green", {13'h0, red, green, blue}, 16'h0002);
    check("start_strip", {left, right}, 16'h1008);

    for (int i = 0; i < 9; i++) pulse(P1R);
    check("p1_right_stop", {left, right}, 16'h1800);
    pulse(P2R);
    check("p2_right", {left, right}, 16'h2800);
    pulse(P2L);
    check("p2_left", {left, right}, 16'h1800);
    pulse(P1L);
    check("p1_left", {left, right}, 16'h1400);
    pulse(P1R | P2L);
    check("gap2_contention", {left, right}, 16'h1800);

    pulse(P1A);
    check("hit1_ss0", {8'h00, ss0}, {8'h00, SEGT[8]});
    pulse(P1A);
    check("cooldown_block", {8'h00, ss0}, {8'h00, SEGT[8]});
    tick(55);
    for (int h = 7; h >= 0; h--) begin
      pulse(P1A);
      check("hit_ss0", {8'h00, ss0}, {8'h00, SEGT[h]});
      tick(55);
    end
    check("p1win_rgb", {13'h0, red, green, blue}, 16'h0004);
    check("p1win_ss7", {8'h00, ss7}, 16'h006F);
    pulse(P1L);
    check("win_ignores_move", {left, right}, 16'h1800);
    pulse(ST);
    check("restart_strip", {left, right}, 16'h1008);
    check("restart_ss0",   {8'h00, ss0}, 16'h006F);
    check("restart_rgb",   {13'h0, red, green, blue}, 16'h0000);

    pulse(ST);
    check("round2_green", {13'h0, red, green, blue}, 16'h0002);
    pulse(P2A);
    check("far_attack_ss7", {8'h00, ss7}, 16'h006F);
    tick(55);
    for (int i = 0; i < 8; i++) pulse(P1R);
    check("round2_adjacent", {left, right}, 16'h1800);
    for (int h = 8; h >= 1; h--) begin
      pulse(P1A | P2A);
      check("trade_ss7", {8'h00, ss7}, {8'h00, SEGT[h]});
      check("trade_ss0", {8'h00, ss0}, {8'h00, SEGT[h]});
      tick(55);
    end
    check("h1_still_play", {13'h0, red, green, blue}, 16'h0002);
    pulse(P1A | P2A);
    tick(2);
    check("draw_rgb", {13'h0, red, green, blue}, 16'h0005);
    check("draw_ss7", {8'h00, ss7}, 16'h003F);
    check("draw_ss0", {8'h00, ss0}, 16'h003F);

    pb = pb | ST;
    tick(6000);
    check("held_start_rgb",   {13'h0, red, green, blue}, 16'h0000);
    check("held_start_strip", {left, right}, 16'h1008);
    check("held_start_ss7",   {8'h00, ss7}, 16'h006F);
    pb = pb & ~ST;
    tick(5);

    pulse(ST);
    pulse(P1R);
    check("pre_reset_strip", {left, right}, 16'h1010);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_reset_strip", {left, right}, 16'h1008);
    check("mid_reset_rgb",   {13'h0, red, green, blue}, 16'h0000);
    tick(10);
    check("post_reset_idle", {13'h0, red, green, blue}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
